fetch_exec_controller: RTL
==========================

// Module: fetch_exec_controller
// PURPOSE
//  Moore FSM that sequences the processor's instruction-fetch datapath (PC counter, instruction memory, IR).
//  Drives pc_clr/pc_up/ir_ld into the fetch unit, consumes the IR word, and issues data-memory,
//  register-file and ALU controls for each instruction. It sits between the fetch unit and the datapath.
// PARAMETERS
//  IR_W     16  instruction width; opcode = ir_in[15:12]
//  DADDR_W   8  data-memory address width
//  RADDR_W   4  register-file address width
//  ALU_W     3  ALU select width
// PORTS
//  clk          in   1        system clock, all state changes on rising edge
//  reset_n      in   1        synchronous, active-low reset
//  ir_in        in   IR_W     current IR contents from the fetch unit
//  pc_clr       out  1        clear program counter to 0
//  pc_up        out  1        increment program counter
//  ir_ld        out  1        load IR from instruction-memory output
//  d_addr       out  DADDR_W  data-memory address
//  d_wr         out  1        data-memory write enable
//  rf_sel       out  2        RF write-data mux: 00 ALU result, 01 data-memory q
//  rf_w_addr    out  RADDR_W  RF write address
//  rf_w_en      out  1        RF write enable
//  rf_ra_addr   out  RADDR_W  RF read port A address
//  rf_rb_addr   out  RADDR_W  RF read port B address
//  alu_sel      out  ALU_W    000 pass A, 001 A+B, 010 A-B
//  halted       out  1        high while in HALT
//  state_o      out  4        current state encoding, for debug/bench
// BEHAVIOUR
//  - Single clock and synchronous active-low reset: reset_n==0 at a rising edge -> state INIT, regardless of current state.
//  - Outputs are decoded combinationally from the registered state and ir_in; they are not registered.
//    Any output not listed for a state is 0.
//  - Reset/INIT outputs: pc_clr=1, all other outputs 0, state_o=0.
//  - Instruction encodings:
//      0000 NOOP
//      0001 LOAD   [11:4]=d_addr, [3:0]=W
//      0010 STORE  [11:8]=Ra, [7:0]=d_addr
//      0011 ADD    [11:8]=Ra, [7:4]=Rb, [3:0]=W
//      0100 SUB    same fields as ADD
//      0101 HALT
//    Opcodes 0110-1111 execute as NOOP.
//  - Instruction memory has a 1-cycle registered read latency.
//  - States and transitions:
//      INIT(0)     -> PREFETCH. pc_clr=1.
//      PREFETCH(1) -> FETCH. No controls asserted; gives memory q one cycle to reflect address 0.
//      FETCH(2)    -> DECODE. ir_ld=1, pc_up=1 in the same cycle. IR captures q(PC) and PC increments on the same edge.
//      DECODE(3)   -> LOAD_A / STORE / ADD / SUB / HALT / NOOP, selected by ir_in[15:12].
//      NOOP(4)     -> FETCH.
//      LOAD_A(5)   -> LOAD_B. d_addr=ir[11:4], rf_sel=01.
//      LOAD_B(6)   -> FETCH. d_addr and rf_sel held; rf_w_en=1, rf_w_addr=ir[3:0].
//      STORE(7)    -> FETCH. d_addr=ir[7:0], rf_ra_addr=ir[11:8], d_wr=1.
//      ADD(8)      -> FETCH. rf_ra_addr=ir[11:8], rf_rb_addr=ir[7:4], alu_sel=001, rf_sel=00, rf_w_en=1, rf_w_addr=ir[3:0].
//      SUB(9)      -> FETCH. Same as ADD with alu_sel=010.
//      HALT(10)    -> HALT. halted=1. Only reset exits this state.
//  - Latency: NOOP/STORE/ADD/SUB take 3 cycles (FETCH, DECODE, exec); LOAD takes 4.
//    PREFETCH occurs only once, after INIT.
//  - Every instruction passes through at least 2 cycles between FETCH pulses, so the PC output is stable one cycle before each ir_ld.
//  - Write strobes (d_wr, rf_w_en) are high for exactly one cycle per instruction and never in FETCH/DECODE.
//  - pc_up and pc_clr are never high together. The controller does not check PC wrap-around; at 127 the PC wraps to 0 in the counter.
//  - Reset mid-operation (for example in LOAD_A): rf_w_en, d_wr and pc_up are 0 from the reset edge onward; no partial write occurs.
//  - Unused state encodings (11-15) go to INIT on the next edge.
// STRUCTURE
//  - Package ctrl_pkg holds: opcode_t enum (NOOP..HALT), state_t enum (4-bit values above),
//    ALU_PASS/ALU_ADD/ALU_SUB and RF_SEL_ALU/RF_SEL_MEM constants.
//  - No sub-module: one next-state always_comb, one state always_ff, one output always_comb.
// TESTING
//  - Hold reset_n=0 for 2 edges -> pc_clr=1, others 0, state_o=0. Release -> INIT, PREFETCH, then FETCH with pc_up=ir_ld=1.
//  - ir_in=16'h1A53 (LOAD) -> LOAD_A: d_addr=8'hA5, rf_sel=01. LOAD_B: rf_w_en=1, rf_w_addr=3. Then FETCH.
//  - ir_in=16'h2A7B (STORE) -> one cycle with d_wr=1, d_addr=8'h7B, rf_ra_addr=4'hA; rf_w_en stays 0.
//  - ir_in=16'h3123 (ADD) -> alu_sel=001, Ra=1, Rb=2, rf_w_en=1, W=3.
//    ir_in=16'h4456 (SUB) -> alu_sel=010, Ra=4, Rb=5, W=6.
//  - ir_in=16'h5000 (HALT) -> halted=1 and pc_up=0 for 20+ cycles; reset_n=0 -> INIT.
//    ir_in=16'hF000 -> NOOP path, 3 cycles, no strobes.
//  - Assert reset_n=0 while in LOAD_A -> next edge INIT, rf_w_en never 1.
//    Also check every cycle that pc_up&&pc_clr==0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction fetch/execute sequencer.
// Encodings are visible on state_o, so the state values are fixed and must not be reordered.
package ctrl_pkg;

   localparam int IR_W    = 16;
   localparam int DADDR_W = 8;
   localparam int RADDR_W = 4;
   localparam int ALU_W   = 3;

   typedef enum logic [3:0] {
      OP_NOOP  = 4'd0,
      OP_LOAD  = 4'd1,
      OP_STORE = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_HALT  = 4'd5
   } opcode_t;

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_PREFETCH = 4'd1,
      ST_FETCH    = 4'd2,
      ST_DECODE   = 4'd3,
      ST_NOOP     = 4'd4,
      ST_LOAD_A   = 4'd5,
      ST_LOAD_B   = 4'd6,
      ST_STORE    = 4'd7,
      ST_ADD      = 4'd8,
      ST_SUB      = 4'd9,
      ST_HALT     = 4'd10
   } state_t;

   localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
   localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

   localparam logic [1:0] RF_SEL_ALU = 2'b00;
   localparam logic [1:0] RF_SEL_MEM = 2'b01;

   // Opcodes outside the defined set execute as NOOP.
   function automatic state_t exec_state(input logic [3:0] op);
      state_t st;
      case (op)
         OP_LOAD:  st = ST_LOAD_A;
         OP_STORE: st = ST_STORE;
         OP_ADD:   st = ST_ADD;
         OP_SUB:   st = ST_SUB;
         OP_HALT:  st = ST_HALT;
         default:  st = ST_NOOP;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/fetch_exec_controller.sv
// Moore sequencer driving the PC/IMEM/IR fetch unit and the data-memory, register-file and ALU
// controls for each instruction.
//
// state        | meaning
// -------------+------------------------------------------------------------
// INIT     (0) | after reset; clear PC
// PREFETCH (1) | one idle cycle so IMEM q reflects address 0
// FETCH    (2) | load IR from IMEM and increment PC on the same edge
// DECODE   (3) | branch on ir_in opcode
// NOOP     (4) | no operation (also opcodes 6-15)
// LOAD_A   (5) | present data-memory address, select memory q on RF mux
// LOAD_B   (6) | hold address/mux, write RF
// STORE    (7) | read Ra, write data memory
// ADD      (8) | Ra + Rb -> W
// SUB      (9) | Ra - Rb -> W
// HALT    (10) | stopped; only reset leaves
module fetch_exec_controller
   import ctrl_pkg::*;
#(
   parameter int IR_W    = ctrl_pkg::IR_W,
   parameter int DADDR_W = ctrl_pkg::DADDR_W,
   parameter int RADDR_W = ctrl_pkg::RADDR_W,
   parameter int ALU_W   = ctrl_pkg::ALU_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [IR_W-1:0]    ir_in,
   output logic               pc_clr,
   output logic               pc_up,
   output logic               ir_ld,
   output logic [DADDR_W-1:0] d_addr,
   output logic               d_wr,
   output logic [1:0]         rf_sel,
   output logic [RADDR_W-1:0] rf_w_addr,
   output logic               rf_w_en,
   output logic [RADDR_W-1:0] rf_ra_addr,
   output logic [RADDR_W-1:0] rf_rb_addr,
   output logic [ALU_W-1:0]   alu_sel,
   output logic               halted,
   output logic [3:0]         state_o
);

   state_t r_state;
   state_t w_next;

   logic [3:0]         w_opcode;
   logic [DADDR_W-1:0] w_ld_addr;
   logic [DADDR_W-1:0] w_st_addr;
   logic [RADDR_W-1:0] w_ra;
   logic [RADDR_W-1:0] w_rb;
   logic [RADDR_W-1:0] w_wa;

   assign w_opcode  = ir_in[15:12];
   assign w_ld_addr = ir_in[11:4];
   assign w_st_addr = ir_in[7:0];
   assign w_ra      = ir_in[11:8];
   assign w_rb      = ir_in[7:4];
   assign w_wa      = ir_in[3:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   // Unused encodings fall through to INIT.
   always_comb begin
      w_next = ST_INIT;
      case (r_state)
         ST_INIT:     w_next = ST_PREFETCH;
         ST_PREFETCH: w_next = ST_FETCH;
         ST_FETCH:    w_next = ST_DECODE;
         ST_DECODE:   w_next = exec_state(w_opcode);
         ST_NOOP:     w_next = ST_FETCH;
         ST_LOAD_A:   w_next = ST_LOAD_B;
         ST_LOAD_B:   w_next = ST_FETCH;
         ST_STORE:    w_next = ST_FETCH;
         ST_ADD:      w_next = ST_FETCH;
         ST_SUB:      w_next = ST_FETCH;
         ST_HALT:     w_next = ST_HALT;
         default:     w_next = ST_INIT;
      endcase
   end

   always_comb begin
      pc_clr     = 1'b0;
      pc_up      = 1'b0;
      ir_ld      = 1'b0;
      d_addr     = '0;
      d_wr       = 1'b0;
      rf_sel     = RF_SEL_ALU;
      rf_w_addr  = '0;
      rf_w_en    = 1'b0;
      rf_ra_addr = '0;
      rf_rb_addr = '0;
      alu_sel    = ALU_PASS;
      halted     = 1'b0;
      case (r_state)
         ST_INIT: begin
            pc_clr = 1'b1;
         end
         ST_FETCH: begin
            ir_ld = 1'b1;
            pc_up = 1'b1;
         end
         ST_LOAD_A: begin
            d_addr = w_ld_addr;
            rf_sel = RF_SEL_MEM;
         end
         ST_LOAD_B: begin
            d_addr    = w_ld_addr;
            rf_sel    = RF_SEL_MEM;
            rf_w_en   = 1'b1;
            rf_w_addr = w_wa;
         end
         ST_STORE: begin
            d_addr     = w_st_addr;
            rf_ra_addr = w_ra;
            d_wr       = 1'b1;
         end
         ST_ADD: begin
            rf_ra_addr = w_ra;
            rf_rb_addr = w_rb;
            alu_sel    = ALU_ADD;
            rf_sel     = RF_SEL_ALU;
            rf_w_en    = 1'b1;
            rf_w_addr  = w_wa;
         end
         ST_SUB: begin
            rf_ra_addr = w_ra;
            rf_rb_addr = w_rb;
            alu_sel    = ALU_SUB;
            rf_sel     = RF_SEL_ALU;
            rf_w_en    = 1'b1;
            rf_w_addr  = w_wa;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign state_o = r_state;

endmodule
